fsm_dispatch: RTL



---
 rtl/fsm_dispatch_pkg.sv | 44 ++++
 rtl/fsm_dispatch_code_to_unit.sv | 29 ++
 rtl/fsm_dispatch.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fsm_dispatch_pkg.sv
// Shared definitions for the dispatch sequencer: state encoding, execution
// unit indices and the per-unit instruction-class masks from the opdecoder.
package fsm_dispatch_pkg;

    // Sequencer states; any other 3-bit value is treated as IDLE.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'b000,
        ST_FETCH     = 3'b001,
        ST_SETTLE    = 3'b010,
        ST_DISPATCH  = 3'b011,
        ST_WAIT_DONE = 3'b100,
        ST_TRAP      = 3'b111
    } state_e;

    localparam int UNIT_ALU    = 0;
    localparam int UNIT_LOAD   = 1;
    localparam int UNIT_STORE  = 2;
    localparam int UNIT_BRANCH = 3;
    localparam int UNIT_JUMP   = 4;
    localparam int UNIT_FLOAT  = 5;

    // One-hot class bits owned by each unit. Bits 25..31 belong to no unit
    // and therefore decode as illegal.
    localparam logic [31:0] MASK_ALU    = 32'h0000_7060; // bits 5,6,12,13,14
    localparam logic [31:0] MASK_LOAD   = 32'h0000_0007; // bits 0..2
    localparam logic [31:0] MASK_STORE  = 32'h0000_0018; // bits 3..4
    localparam logic [31:0] MASK_BRANCH = 32'h0000_0F80; // bits 7..11
    localparam logic [31:0] MASK_JUMP   = 32'h0001_8000; // bits 15..16
    localparam logic [31:0] MASK_FLOAT  = 32'h01FE_0000; // bits 17..24

    // Mask lookup by unit index; indices beyond the known units own no bits.
    function automatic logic [31:0] unit_mask(input int unsigned idx);
        case (idx)
            UNIT_ALU:    return MASK_ALU;
            UNIT_LOAD:   return MASK_LOAD;
            UNIT_STORE:  return MASK_STORE;
            UNIT_BRANCH: return MASK_BRANCH;
            UNIT_JUMP:   return MASK_JUMP;
            UNIT_FLOAT:  return MASK_FLOAT;
            default:     return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/fsm_dispatch_code_to_unit.sv
// Combinational class decoder: maps the opdecoder's one-hot code onto the
// execution units, encodes the selected unit index and flags whether exactly
// one unit claimed the code.
module code_to_unit
    import fsm_dispatch_pkg::*;
#(
    parameter int N_FSM = 6,
    parameter int SEL_W = 3
) (
    input  logic [31:0]      code,
    output logic [N_FSM-1:0] unit_vec,
    output logic [SEL_W-1:0] unit_idx,
    output logic             unit_onehot
);

    // Per-unit OR-reduction of masked code, index encode, and one-hot test.
    always_comb begin
        unit_vec = '0;
        unit_idx = '0;
        for (int i = 0; i < N_FSM; i++) begin
            unit_vec[i] = |(code & unit_mask(i));
            if (unit_vec[i]) begin
                unit_idx = unit_idx | SEL_W'(i);
            end
        end
        unit_onehot = (unit_vec != '0) && ((unit_vec & (unit_vec - N_FSM'(1))) == '0);
    end

endmodule

// File: rtl/fsm_dispatch.sv
// Top-level sequencer of the control unit: fetch, settle, dispatch to one
// execution FSM, wait for its done, retire. Traps on illegal/ambiguous codes.
// Optional watchdog on WAIT_DONE is compiled in with FSM_DISPATCH_WDT_EN.
//
// Handshake: the sequencer issues a single-cycle start_vec pulse and owns no
// back-pressure; the execution FSM answers with done_vec[sel_fsm], which is
// only looked at while in WAIT_DONE. mem_req/mem_ready form a request/grant
// pair: the IR is loaded in the cycle where both are high.
module fsm_dispatch
    import fsm_dispatch_pkg::*;
#(
    parameter int N_FSM      = 6,
    parameter int SEL_W      = 3,
    parameter int WDT_CYCLES = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             mem_ready,
    input  logic [31:0]      code,
    input  logic [N_FSM-1:0] done_vec,
    input  logic             trap_clear,
    output logic             mem_req,
    output logic             load_ir,
    output logic [N_FSM-1:0] start_vec,
    output logic [SEL_W-1:0] sel_fsm,
    output logic             busy,
    output logic             illegal,
    output logic             timeout,
    output logic [63:0]      retired,
    output state_e           dbg_state
);

    // Reject configurations that cannot encode every FSM or overflow the watchdog.
    if ((2 ** SEL_W) < N_FSM || WDT_CYCLES < 2 || WDT_CYCLES > 256) begin : g_bad_params
        $error("fsm_dispatch: illegal parameter combination");
    end

    state_e           state_q, state_d;
    logic [SEL_W-1:0] sel_fsm_q, sel_fsm_d;
    logic             illegal_q, illegal_d;
    logic [63:0]      retired_q, retired_d;
    logic [N_FSM-1:0] unit_vec;
    logic [SEL_W-1:0] unit_idx;
    logic             unit_onehot;
    logic             done_sel;

    code_to_unit #(.N_FSM(N_FSM), .SEL_W(SEL_W)) u_code_to_unit (
        .code        (code),
        .unit_vec    (unit_vec),
        .unit_idx    (unit_idx),
        .unit_onehot (unit_onehot)
    );

    // Pick the done bit of the FSM that currently owns the datapath.
    always_comb begin
        done_sel = 1'b0;
        for (int i = 0; i < N_FSM; i++) begin
            if (sel_fsm_q == SEL_W'(i)) begin
                done_sel = done_vec[i];
            end
        end
    end

`ifdef FSM_DISPATCH_WDT_EN
    localparam logic [7:0] WDT_LIMIT = 8'(WDT_CYCLES - 1);
    logic [7:0] wdt_q, wdt_d;
    logic       timeout_q, timeout_d;

    // Watchdog clears on the way into WAIT_DONE and counts each cycle spent there.
    always_comb begin
        wdt_d = wdt_q;
        if (state_q == ST_DISPATCH) begin
            wdt_d = 8'd0;
        end else if (state_q == ST_WAIT_DONE) begin
            wdt_d = wdt_q + 8'd1;
        end
    end

    // Watchdog and sticky timeout registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdt_q     <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            wdt_q     <= wdt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Next-state logic and per-state outputs.
    always_comb begin
        state_d   = state_q;
        sel_fsm_d = sel_fsm_q;
        illegal_d = illegal_q;
        retired_d = retired_q;
`ifdef FSM_DISPATCH_WDT_EN
        timeout_d = timeout_q;
`endif
        mem_req   = 1'b0;
        load_ir   = 1'b0;
        start_vec = '0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Execution FSMs are not reset, so wait until none is still finishing.
                if (run && (done_vec == '0)) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) begin
                    load_ir = 1'b1;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                busy    = 1'b1;
                state_d = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                busy = 1'b1;
                if (unit_onehot) begin
                    start_vec = unit_vec;
                    sel_fsm_d = unit_idx;
                    state_d   = ST_WAIT_DONE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_WAIT_DONE: begin
                busy = 1'b1;
                if (done_sel) begin
                    retired_d = retired_q + 64'd1;
                    state_d   = run ? ST_FETCH : ST_IDLE;
                end
`ifdef FSM_DISPATCH_WDT_EN
                else if (wdt_q == WDT_LIMIT) begin
                    timeout_d = 1'b1;
                    state_d   = ST_TRAP;
                end
`endif
            end
            ST_TRAP: begin
                if (trap_clear) begin
                    illegal_d = 1'b0;
`ifdef FSM_DISPATCH_WDT_EN
                    timeout_d = 1'b0;
`endif
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath-select, sticky flag and retire-count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_fsm_q <= '0;
            illegal_q <= 1'b0;
            retired_q <= 64'd0;
        end else begin
            state_q   <= state_d;
            sel_fsm_q <= sel_fsm_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign sel_fsm   = sel_fsm_q;
    assign illegal   = illegal_q;
    assign retired   = retired_q;
    assign dbg_state = state_q;

endmodule
